i2s_frame_encoder: RTL and testbench

- Parametrised I2S / left-justified serial transmitter.
- Takes stereo PCM words through a valid/ready handshake and buffers one frame ahead.
- Serialises each frame MSB-first onto o_sdata with a generated o_lrclk.
- Sits between the sample mixer/DAC-feed logic and the external DAC pins; the bit clock (i_bclk) is its only clock.

---
 rtl/i2s_pkg.sv | 24 ++
 rtl/i2s_frame_encoder_if.sv | 20 ++
 rtl/i2s_frame_buffer.sv | 68 ++++++
 rtl/i2s_frame_encoder.sv | 116 +++++++++++
 tb/tb_i2s_frame_encoder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types, slot-width constants and helpers for the I2S frame encoder
// Contents:
//   fmt_e      serial format: FMT_I2S (one-bit delay) or FMT_LJ (left-justified)
//   SLOT_W_*   the slot widths the encoder supports
//   clog2      constant-foldable ceiling log2 used to size the bit counter
package i2s_pkg;

  typedef enum logic {
    FMT_I2S = 1'b0,
    FMT_LJ  = 1'b1
  } fmt_e;

  localparam int SLOT_W_16 = 16;
  localparam int SLOT_W_24 = 24;
  localparam int SLOT_W_32 = 32;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/i2s_frame_encoder_if.sv
// rtl/i2s_frame_encoder_if.sv - stereo PCM valid/ready handshake into the I2S frame encoder
// Signals:
//   i_valid   frame offered by the producer
//   i_data_l  left sample, DATA_W bits, two's complement
//   i_data_r  right sample, DATA_W bits, two's complement
//   o_ready   encoder holding register is empty
// Modports: master = sample producer, slave = encoder.
interface i2s_frame_encoder_if #(
  parameter int DATA_W = 16
);

  logic              i_valid;
  logic [DATA_W-1:0] i_data_l;
  logic [DATA_W-1:0] i_data_r;
  logic              o_ready;

  modport master (output i_valid, output i_data_l, output i_data_r, input o_ready);
  modport slave  (input i_valid, input i_data_l, input i_data_r, output o_ready);

endinterface

// File: rtl/i2s_frame_buffer.sv
// rtl/i2s_frame_buffer.sv - one-frame holding register with handshake and last-frame copy
// Ports:
//   i_bclk     bit clock, state changes on the falling edge
//   i_rst_x    asynchronous active-low reset
//   i_load     frame load strobe from the encoder (counter wrap edge)
//   s_if       producer handshake (slave side)
//   o_empty    holding register empty at this load: the load is an underrun
//   o_load_l   left sample for the frame being loaded
//   o_load_r   right sample for the frame being loaded
module i2s_frame_buffer
  import i2s_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int UNDERRUN_HOLD = 0
) (
  input  logic              i_bclk,
  input  logic              i_rst_x,
  input  logic              i_load,
  i2s_frame_encoder_if.slave s_if,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_load_l,
  output logic [DATA_W-1:0] o_load_r
);

  logic              r_full;
  logic [DATA_W-1:0] r_hold_l;
  logic [DATA_W-1:0] r_hold_r;
  logic [DATA_W-1:0] r_last_l;
  logic [DATA_W-1:0] r_last_r;
  logic              accept;

  assign s_if.o_ready = ~r_full;
  assign o_empty      = ~r_full;
  assign accept       = s_if.i_valid && ~r_full;

  always_comb begin
    o_load_l = '0;
    o_load_r = '0;
    if (r_full) begin
      o_load_l = r_hold_l;
      o_load_r = r_hold_r;
    end else if (UNDERRUN_HOLD != 0) begin
      o_load_l = r_last_l;
      o_load_r = r_last_r;
    end
  end

  // A load drains a full register; when the register is empty at the load,
  // a handshake on that same edge still fills it for the following frame.
  always_ff @(negedge i_bclk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      r_full   <= 1'b0;
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_last_l <= '0;
      r_last_r <= '0;
    end else if (i_load && r_full) begin
      r_full   <= 1'b0;
      r_last_l <= r_hold_l;
      r_last_r <= r_hold_r;
    end else if (accept) begin
      r_full   <= 1'b1;
      r_hold_l <= s_if.i_data_l;
      r_hold_r <= s_if.i_data_r;
    end
  end

endmodule

// File: rtl/i2s_frame_encoder.sv
// rtl/i2s_frame_encoder.sv - parametrised I2S / left-justified serial transmitter (top)
// Optional feature macro: I2S_ENC_UNDERRUN_CNT_EN adds o_underrun_cnt.
// Ports:
//   i_bclk          bit clock; all state changes on the falling edge
//   i_rst_x         asynchronous active-low reset
//   i_fmt           0 = I2S, 1 = left-justified, latched at each frame load
//   s_if            stereo PCM valid/ready handshake (slave side)
//   o_lrclk         word select, 0 = left slot, 1 = right slot
//   o_sdata         serial data, MSB first
//   o_frame_start   one-period pulse in the first period of each frame
//   o_underrun      one-period pulse when a frame loads with no data held
//   o_underrun_cnt  saturating underrun count (macro builds only)
module i2s_frame_encoder
  import i2s_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int SLOT_W        = 32,
  parameter int UNDERRUN_HOLD = 0
) (
  input  logic        i_bclk,
  input  logic        i_rst_x,
  input  logic        i_fmt,
  i2s_frame_encoder_if.slave s_if,
  output logic        o_lrclk,
  output logic        o_sdata,
  output logic        o_frame_start,
  output logic        o_underrun
`ifdef I2S_ENC_UNDERRUN_CNT_EN
  ,
  output logic [15:0] o_underrun_cnt
`endif
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int CNT_W   = clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_W);

  if (DATA_W < 1 || DATA_W > SLOT_W) begin : g_bad_data_w
    $error("i2s_frame_encoder: DATA_W must be within 1..SLOT_W");
  end
  if (SLOT_W != SLOT_W_16 && SLOT_W != SLOT_W_24 && SLOT_W != SLOT_W_32) begin : g_bad_slot_w
    $error("i2s_frame_encoder: SLOT_W must be 16, 24 or 32");
  end

  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   count_next;
  logic               load;
  logic               buf_empty;
  logic [DATA_W-1:0]  buf_l;
  logic [DATA_W-1:0]  buf_r;
  logic [SLOT_W-1:0]  slot_l;
  logic [SLOT_W-1:0]  slot_r;
  logic [FRAME_W-1:0] r_shift;
  logic               r_sdata_dly;
  fmt_e               r_fmt;

  i2s_frame_buffer #(
    .DATA_W        (DATA_W),
    .UNDERRUN_HOLD (UNDERRUN_HOLD)
  ) u_frame_buffer (
    .i_bclk   (i_bclk),
    .i_rst_x  (i_rst_x),
    .i_load   (load),
    .s_if     (s_if),
    .o_empty  (buf_empty),
    .o_load_l (buf_l),
    .o_load_r (buf_r)
  );

  assign load       = (r_count == CNT_LAST);
  assign count_next = load ? '0 : r_count + CNT_W'(1);

  // Samples sit MSB-aligned in their slot with zero padding below.
  assign slot_l = SLOT_W'(buf_l) << (SLOT_W - DATA_W);
  assign slot_r = SLOT_W'(buf_r) << (SLOT_W - DATA_W);

  // LJ drives the shifter MSB directly; I2S uses the one-period delayed copy,
  // so the last right bit of a full-width slot spills into the next frame.
  assign o_sdata = (r_fmt == FMT_LJ) ? r_shift[FRAME_W-1] : r_sdata_dly;

  always_ff @(negedge i_bclk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      r_count       <= '0;
      o_lrclk       <= 1'b0;
      o_frame_start <= 1'b0;
      o_underrun    <= 1'b0;
      r_shift       <= '0;
      r_sdata_dly   <= 1'b0;
      r_fmt         <= FMT_I2S;
    end else begin
      r_count       <= count_next;
      o_lrclk       <= (count_next >= CNT_SLOT);
      o_frame_start <= load;
      o_underrun    <= load && buf_empty;
      r_sdata_dly   <= r_shift[FRAME_W-1];
      if (load) begin
        r_shift <= {slot_l, slot_r};
        r_fmt   <= fmt_e'(i_fmt);
      end else begin
        r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
      end
    end
  end

`ifdef I2S_ENC_UNDERRUN_CNT_EN
  always_ff @(negedge i_bclk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      o_underrun_cnt <= '0;
    end else if (load && buf_empty && o_underrun_cnt != 16'hFFFF) begin
      o_underrun_cnt <= o_underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_frame_encoder.sv
// tb/tb_i2s_frame_encoder.sv - directed self-checking bench for i2s_frame_encoder
module tb_i2s_frame_encoder;

  localparam logic [63:0] I2S_EXP = {1'b0, 16'hA5C3, 16'h0000, 16'h0F0F, 15'h0000};
  localparam logic [63:0] LJ_EXP  = {16'hA5C3, 16'h0000, 16'h0F0F, 16'h0000};
  localparam logic [63:0] LR_EXP  = {32'h0000_0000, 32'hFFFF_FFFF};
  localparam logic [63:0] B_F1_EXP = {15'h0, 1'b0, 24'hC00000, 24'h000001};
  localparam logic [63:0] B_F2_EXP = {16'h0, 24'hC00000, 24'h000001};

  logic bclk = 1'b1;
  logic rst_x;
  logic fmt_a, fmt_b;
  logic lrclk_a, sdata_a, fs_a, und_a;
  logic lrclk_b, sdata_b, fs_b, und_b;
`ifdef I2S_ENC_UNDERRUN_CNT_EN
  logic [15:0] ucnt_a, ucnt_b;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 bclk = ~bclk;

  i2s_frame_encoder_if #(.DATA_W(16)) a_if ();
  i2s_frame_encoder_if #(.DATA_W(24)) b_if ();

  i2s_frame_encoder #(.DATA_W(16), .SLOT_W(32), .UNDERRUN_HOLD(0)) dut_a (
    .i_bclk        (bclk),
    .i_rst_x       (rst_x),
    .i_fmt         (fmt_a),
    .s_if          (a_if),
    .o_lrclk       (lrclk_a),
    .o_sdata       (sdata_a),
    .o_frame_start (fs_a),
    .o_underrun    (und_a)
`ifdef I2S_ENC_UNDERRUN_CNT_EN
    ,
    .o_underrun_cnt(ucnt_a)
`endif
  );

  i2s_frame_encoder #(.DATA_W(24), .SLOT_W(24), .UNDERRUN_HOLD(1)) dut_b (
    .i_bclk        (bclk),
    .i_rst_x       (rst_x),
    .i_fmt         (fmt_b),
    .s_if          (b_if),
    .o_lrclk       (lrclk_b),
    .o_sdata       (sdata_b),
    .o_frame_start (fs_b),
    .o_underrun    (und_b)
`ifdef I2S_ENC_UNDERRUN_CNT_EN
    ,
    .o_underrun_cnt(ucnt_b)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_fs(input bit sel);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (n < 300 && !seen) begin
      @(posedge bclk);
      n++;
      seen = sel ? fs_b : fs_a;
    end
    check(sel ? "fs_wait_b" : "fs_wait_a", 64'(seen), 64'd1);
  endtask

  // Called at the period-0 sample point; returns at the period-63 sample point.
  task automatic cap_a(input int tgl_p, input bit do_send,
                       output logic [63:0] sd, output logic [63:0] lr);
    for (int p = 0; p < 64; p++) begin
      sd[63-p] = sdata_a;
      lr[63-p] = lrclk_a;
      if (p == tgl_p) fmt_a = ~fmt_a;
      if (do_send && p == 5) begin
        check("rdy_pre_accept", 64'(a_if.o_ready), 64'd1);
        a_if.i_valid  = 1'b1;
        a_if.i_data_l = 16'hA5C3;
        a_if.i_data_r = 16'h0F0F;
      end
      if (do_send && p == 6) a_if.i_valid = 1'b0;
      if (do_send && p == 8) check("rdy_post_accept", 64'(a_if.o_ready), 64'd0);
      if (p < 63) @(posedge bclk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] sd, lr;
    int acc, n;

    rst_x = 1'b1;
    fmt_a = 1'b0;
    fmt_b = 1'b0;
    a_if.i_valid = 1'b0; a_if.i_data_l = '0; a_if.i_data_r = '0;
    b_if.i_valid = 1'b0; b_if.i_data_l = '0; b_if.i_data_r = '0;
    #1 rst_x = 1'b0;
    repeat (3) @(posedge bclk);

    check("rst_sdata", 64'(sdata_a), 64'd0);
    check("rst_lrclk", 64'(lrclk_a), 64'd0);
    check("rst_fs", 64'(fs_a), 64'd0);
    check("rst_und", 64'(und_a), 64'd0);
    check("rst_ready", 64'(a_if.o_ready), 64'd1);
`ifdef I2S_ENC_UNDERRUN_CNT_EN
    check("rst_ucnt", 64'(ucnt_a), 64'd0);
`endif

    // Release in period 0 and offer the first frame immediately.
    rst_x = 1'b1;
    a_if.i_valid  = 1'b1;
    a_if.i_data_l = 16'hA5C3;
    a_if.i_data_r = 16'h0F0F;
    @(posedge bclk);
    a_if.i_valid = 1'b0;

    // Frame 1: I2S; toggle to LJ mid-frame and queue the next frame.
    wait_fs(1'b0);
    check("und_f1", 64'(und_a), 64'd0);
    cap_a(10, 1'b1, sd, lr);
    check("i2s_f1", sd, I2S_EXP);
    check("lrclk_f1", lr, LR_EXP);

    // Frame 2: LJ; toggle back to I2S mid-frame.
    @(posedge bclk);
    check("fs_f2", 64'(fs_a), 64'd1);
    check("und_f2", 64'(und_a), 64'd0);
    cap_a(20, 1'b1, sd, lr);
    check("lj_f2", sd, LJ_EXP);

    // Frame 3: I2S again.
    @(posedge bclk);
    check("fs_f3", 64'(fs_a), 64'd1);
    cap_a(-1, 1'b0, sd, lr);
    check("i2s_f3", sd, I2S_EXP);

    // Frames 4..6: underrun, zero frames.
    for (int f = 0; f < 3; f++) begin
      @(posedge bclk);
      check("fs_uf", 64'(fs_a), 64'd1);
      check("und_uf", 64'(und_a), 64'd1);
      cap_a(-1, 1'b0, sd, lr);
      check("zero_uf", sd, 64'd0);
    end
`ifdef I2S_ENC_UNDERRUN_CNT_EN
    check("ucnt_3", 64'(ucnt_a), 64'd3);
`endif

    // Back-to-back: valid held high; the accept lands on the frame-7 load edge.
    a_if.i_valid = 1'b1;
    for (int f = 0; f < 4; f++) begin
      acc = 0;
      for (int p = 0; p < 64; p++) begin
        @(posedge bclk);
        if (p == 0) begin
          check("fs_b2b", 64'(fs_a), 64'd1);
          check("und_b2b", 64'(und_a), 64'(f == 0));
        end
        if (a_if.o_ready) acc++;
      end
      check("accepts_b2b", 64'(acc), (f == 0) ? 64'd0 : 64'd1);
    end
    a_if.i_valid = 1'b0;
`ifdef I2S_ENC_UNDERRUN_CNT_EN
    check("ucnt_4", 64'(ucnt_a), 64'd4);
`endif

    // Frame 11 carries data; fill holding, then reset mid-frame.
    for (int p = 0; p < 38; p++) begin
      @(posedge bclk);
      if (p == 0) check("fs_f11", 64'(fs_a), 64'd1);
      if (p == 5) a_if.i_valid = 1'b1;
      if (p == 6) a_if.i_valid = 1'b0;
    end
    check("sd_p37", 64'(sdata_a), 64'd1);
    check("lrclk_p37", 64'(lrclk_a), 64'd1);
    check("ready_p37", 64'(a_if.o_ready), 64'd0);

    rst_x = 1'b0;
    #1;
    check("midrst_sdata", 64'(sdata_a), 64'd0);
    check("midrst_lrclk", 64'(lrclk_a), 64'd0);
    check("midrst_ready", 64'(a_if.o_ready), 64'd1);
    check("midrst_fs", 64'(fs_a), 64'd0);
`ifdef I2S_ENC_UNDERRUN_CNT_EN
    check("midrst_ucnt", 64'(ucnt_a), 64'd0);
`endif
    @(posedge bclk);
    @(posedge bclk);
    rst_x = 1'b1;
    n = 0;
    do begin
      @(posedge bclk);
      n++;
    end while (!fs_a && n < 300);
    check("restart_latency", 64'(n), 64'd64);
    check("und_after_rst", 64'(und_a), 64'd1);

    // 24/24 instance, I2S, repeat-on-underrun.
    check("b_ready", 64'(b_if.o_ready), 64'd1);
    b_if.i_valid  = 1'b1;
    b_if.i_data_l = 24'hC00000;
    b_if.i_data_r = 24'h000001;
    @(posedge bclk);
    b_if.i_valid = 1'b0;
    wait_fs(1'b1);
    check("b_und_f1", 64'(und_b), 64'd0);
    sd = '0;
    for (int p = 0; p < 49; p++) begin
      sd[48-p] = sdata_b;
      if (p == 48) begin
        check("b_lsb_lrclk", 64'(lrclk_b), 64'd0);
        check("b_lsb_fs", 64'(fs_b), 64'd1);
        check("b_hold_und", 64'(und_b), 64'd1);
      end
      if (p < 48) @(posedge bclk);
    end
    check("b_i2s_f1", sd, B_F1_EXP);
    sd = '0;
    for (int p = 1; p < 49; p++) begin
      @(posedge bclk);
      sd[48-p] = sdata_b;
    end
    check("b_repeat_f2", sd, B_F2_EXP);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
